csr_counter_unit: RTL and testbench
===================================

# csr_counter_unit

- Execution-side CSR responder for the counter/ID CSRs `misa`, `mcycle`, `minstret`, `mcycleh` and `minstreth`.
- Accepts decoded SYSTEM CSR instructions (CSRRW/S/C and the immediate forms) from the core pipeline and performs the privilege and read-only access checks.
- Updates the architectural counters.
- Emits a registered response carrying `rd` writeback, the trap flag, and the RVFI CSR rmask/wmask/rdata/wdata fields that the formal CSR-write checks consume.

## Interface
Parameters:
- `XLEN`, default 32: register width; only 32 or 64 are legal.
- `MISA_VALUE`, default `32'h40000100` (RV32I): constant `misa` contents, zero-extended to `XLEN`.

Ports:
- `clock` in 1: the single clock.
- `reset` in 1: reset; asynchronous, active-low.
- `req_valid` in 1: instruction offered.
- `req_ready` out 1: unit can accept.
- `req_insn` in 32: instruction word; opcode `7'b1110011`, `funct3[1:0]!=0` guaranteed by the decoder.
- `req_rs1_rdata` in XLEN: rs1 value.
- `req_mode` in 2: current privilege level (0=U, 1=S, 3=M).
- `retire` in 1: one instruction retired this cycle; counted into `minstret`.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer accepts the response.
- `resp_trap` out 1: illegal access.
- `resp_rd_addr` out 5: writeback register address.
- `resp_rd_wdata` out XLEN: writeback data.
- `csr_misa_{rmask,wmask,rdata,wdata}` out XLEN: RVFI fields for `misa`.
- `csr_mcycle_{rmask,wmask,rdata,wdata}` out 64: RVFI fields for `mcycle`; `mcycleh` accesses are reported here in bits [63:32].
- `csr_minstret_{rmask,wmask,rdata,wdata}` out 64: RVFI fields for `minstret`; `minstreth` accesses are reported here in bits [63:32].

## Operation
FSM states:
- `IDLE`: `req_ready=1`. On `req_valid`, the request is accepted and the FSM moves to `RESP`.
- `RESP`: `req_ready=0`, `resp_valid=1`. Moves to `IDLE` when `resp_ready` is high.

Instruction decode:
- addr = `insn[31:20]`.
- arg = `insn[14]` ? `insn[19:15]` zero-extended : `rs1_rdata`.
- write = `!insn[13] || insn[19:15]!=0`.
- new value: CSRRW = arg; CSRRS = old|arg; CSRRC = old&~arg.

Address map:
- `misa` is at 301.
- `mcycle` is at B00 (M) and C00 (U read-only).
- `minstret` is at B02 and C02.
- High halves: B80/C80 and B82/C82.

Trap conditions, any of:
- unmapped address;
- `addr[9:8] > mode`;
- `addr[11:10]==2'b11` && write.

On trap:
- `rd_addr=0`, `rd_wdata=0`, all masks 0, no state change.

No trap:
- `rd_addr=insn[11:7]`.
- `rd_wdata` = old value of the addressed half, or 0 when `rd=0`.
- rmask = ones over the accessed bits when `rd!=0`, else 0.
- wmask = ones over the accessed bits when write, else 0.
- rdata = old full register; wdata = new full register.

`misa` is WARL-constant: writes are accepted without a trap, `wmask` stays 0 and the value is unchanged.

For 64-bit counters with `XLEN=32`:
- A low-half access touches bits [31:0] only; upper-half mask bits are 0 and the upper half is unchanged.
- A high-half access is the mirror case.

With `XLEN=64`, accesses use the full 64 bits.

Counter rules:
- `mcycle` increments by 1 every cycle.
- `minstret` increments by 1 on each cycle with `retire=1`.
- Both wrap from 2^64-1 to 0.

## Timing
- Accept at cycle T (`req_valid && req_ready`). The CSR write commits at the T→T+1 edge, and `resp_*` is registered at the same edge and valid from T+1.
- Response latency is 1 cycle. Back-to-back throughput is one request per 2 cycles; the next acceptance is at T+2 at the earliest.
- rdata is the counter value sampled in cycle T.
- A write in cycle T suppresses that cycle's increment of the written counter, so the written value lands exactly. This applies to both halves, and the write wins over a simultaneous `retire`. The unwritten counter increments normally.
- `resp_*` outputs are held stable while `resp_valid && !resp_ready`; counters keep running.
- Asynchronous reset, at any point including mid-RESP:
  - state goes to `IDLE`;
  - `resp_valid=0`, `req_ready=0` while reset is asserted, then 1 after release;
  - `resp_trap=0`, rd fields 0, all mask/data outputs 0;
  - `mcycle=minstret=0`.

## Configuration
`CSR_COUNTER_HIGH_EN`:
- Defined with `XLEN=32`: B80/B82/C80/C82 map to the high halves as described under Operation.
- Undefined, or with `XLEN=64`: these addresses are unmapped and trap.
- Low-half behaviour is identical in both cases.

## Test plan
- Reset, then M-mode `csrrs x5, mcycle, x0` accepted at cycle 10 → `resp_valid` at 11, `rd_wdata=10`, `rmask=64'hFFFFFFFF`, `wmask=0`, no trap.
- M-mode `csrrw x0, minstret, x7` with `rs1=32'h55`, and `retire=1` in the same cycle → next-cycle `minstret=0x55`, `wdata=0x55`, `wmask=64'hFFFFFFFF`, `rd_addr=0`, `rd_wdata=0`.
- U-mode `csrrw x1, mcycle, x2` → `resp_trap=1`, `rd_addr=0`, all masks 0, `mcycle` unaffected.
- U-mode `csrrsi x3, cycle, 1` (C00, write) → trap; U-mode `csrrs x3, cycle, x0` → no trap, `rd_wdata` = count.
- With `CSR_COUNTER_HIGH_EN` and `XLEN=32`, M-mode `csrrw x4, mcycleh, x6` with `rs1=1` → `wmask=64'hFFFFFFFF_00000000`, `mcycle[63:32]=1`, low half continues counting; without the macro, the same instruction traps.
- Response held 5 cycles with `resp_ready=0`, then reset asserted mid-hold → `resp_valid` drops immediately, counters read 0 after release.

Source files
------------

// File: rtl/csr_counter_unit_if.sv
// csr_counter_unit_if
//   Groups the request/response handshake and the RVFI CSR observation
//   fields of csr_counter_unit.
//   master : core pipeline side (drives requests, consumes responses)
//   slave  : csr_counter_unit (accepts requests, produces responses)
//   Request  : req_valid/req_ready, req_insn, req_rs1_rdata, req_mode
//   Response : resp_valid/resp_ready, resp_trap, resp_rd_addr, resp_rd_wdata
//   RVFI     : csr_{misa,mcycle,minstret}_{rmask,wmask,rdata,wdata}
interface csr_counter_unit_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [31:0]     req_insn;
    logic [XLEN-1:0] req_rs1_rdata;
    logic [1:0]      req_mode;

    logic            resp_valid;
    logic            resp_ready;
    logic            resp_trap;
    logic [4:0]      resp_rd_addr;
    logic [XLEN-1:0] resp_rd_wdata;

    logic [XLEN-1:0] csr_misa_rmask, csr_misa_wmask, csr_misa_rdata, csr_misa_wdata;
    logic [63:0]     csr_mcycle_rmask, csr_mcycle_wmask, csr_mcycle_rdata, csr_mcycle_wdata;
    logic [63:0]     csr_minstret_rmask, csr_minstret_wmask, csr_minstret_rdata, csr_minstret_wdata;

    modport master (
        output req_valid, req_insn, req_rs1_rdata, req_mode, resp_ready,
        input  req_ready, resp_valid, resp_trap, resp_rd_addr, resp_rd_wdata,
        input  csr_misa_rmask, csr_misa_wmask, csr_misa_rdata, csr_misa_wdata,
        input  csr_mcycle_rmask, csr_mcycle_wmask, csr_mcycle_rdata, csr_mcycle_wdata,
        input  csr_minstret_rmask, csr_minstret_wmask, csr_minstret_rdata, csr_minstret_wdata
    );

    modport slave (
        input  req_valid, req_insn, req_rs1_rdata, req_mode, resp_ready,
        output req_ready, resp_valid, resp_trap, resp_rd_addr, resp_rd_wdata,
        output csr_misa_rmask, csr_misa_wmask, csr_misa_rdata, csr_misa_wdata,
        output csr_mcycle_rmask, csr_mcycle_wmask, csr_mcycle_rdata, csr_mcycle_wdata,
        output csr_minstret_rmask, csr_minstret_wmask, csr_minstret_rdata, csr_minstret_wdata
    );
endinterface

// File: rtl/csr_counter_unit.sv
// csr_counter_unit
//   Execution-side responder for misa, mcycle(h) and minstret(h). Accepts a
//   decoded CSRRW/S/C(I) instruction, checks privilege and read-only access,
//   updates the counters and returns a registered response with rd writeback,
//   trap flag and RVFI CSR fields. One request per two cycles.
//   Ports:
//     clock  : clock
//     reset  : asynchronous, active-low reset
//     retire : one instruction retired this cycle (counted into minstret)
//     bus    : csr_counter_unit_if.slave (request, response, RVFI fields)
//   Optional feature macro: CSR_COUNTER_HIGH_EN -- maps mcycleh/minstreth
//   (B80/B82/C80/C82) when XLEN=32; otherwise those addresses trap.
module csr_counter_unit #(
    parameter int          XLEN       = 32,
    parameter logic [31:0] MISA_VALUE = 32'h40000100
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                retire,
    csr_counter_unit_if.slave   bus
);

`ifdef CSR_COUNTER_HIGH_EN
    localparam bit HIGH_EN = (XLEN == 32);
`else
    localparam bit HIGH_EN = 1'b0;
`endif

    localparam logic [63:0] LO_MASK = (XLEN == 64) ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] HI_MASK = 64'hFFFF_FFFF_0000_0000;

    typedef enum logic {IDLE, RESP} state_t;

    typedef struct packed {
        logic            trap;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] rd_wdata;
        logic [XLEN-1:0] misa_rmask, misa_wmask, misa_rdata, misa_wdata;
        logic [63:0]     cyc_rmask, cyc_wmask, cyc_rdata, cyc_wdata;
        logic [63:0]     ins_rmask, ins_wmask, ins_rdata, ins_wdata;
    } resp_t;

    state_t      state_q, state_d;
    resp_t       resp_q, resp_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    // ---- decode ----
    logic [11:0]     addr;
    logic [4:0]      rd, zimm;
    logic            rd_nz, wr, accept, req_ready_w;
    logic [XLEN-1:0] arg, old_half, new_half, misa_x;
    logic            sel_misa, sel_cyc_lo, sel_ins_lo, sel_cyc_hi, sel_ins_hi;
    logic            sel_cyc, sel_ins, sel_hi, mapped, trap;
    logic [63:0]     old_full, old64, new_half64, acc_mask, new_full;
    logic            unused_insn;

    assign addr   = bus.req_insn[31:20];
    assign zimm   = bus.req_insn[19:15];
    assign rd     = bus.req_insn[11:7];
    assign rd_nz  = (rd != 5'd0);
    assign arg    = bus.req_insn[14] ? XLEN'(zimm) : bus.req_rs1_rdata;
    assign wr     = !bus.req_insn[13] || (zimm != 5'd0);
    assign misa_x = XLEN'(MISA_VALUE);
    assign unused_insn = ^bus.req_insn[6:0];

    assign sel_misa   = (addr == 12'h301);
    assign sel_cyc_lo = (addr == 12'hB00) || (addr == 12'hC00);
    assign sel_ins_lo = (addr == 12'hB02) || (addr == 12'hC02);
    assign sel_cyc_hi = HIGH_EN && ((addr == 12'hB80) || (addr == 12'hC80));
    assign sel_ins_hi = HIGH_EN && ((addr == 12'hB82) || (addr == 12'hC82));
    assign sel_cyc    = sel_cyc_lo || sel_cyc_hi;
    assign sel_ins    = sel_ins_lo || sel_ins_hi;
    assign sel_hi     = sel_cyc_hi || sel_ins_hi;
    assign mapped     = sel_misa || sel_cyc || sel_ins;

    // addr[11:10]==3 marks the read-only user counter aliases.
    assign trap = !mapped || (addr[9:8] > bus.req_mode) || ((addr[11:10] == 2'b11) && wr);

    assign old_full = sel_ins ? minstret_q : mcycle_q;
    assign old64    = sel_misa ? 64'(misa_x)
                    : (sel_hi ? {32'h0, old_full[63:32]} : old_full);
    assign old_half = old64[XLEN-1:0];
    assign acc_mask = sel_hi ? HI_MASK : LO_MASK;

    always_comb begin
        new_half = arg;
        unique case (bus.req_insn[13:12])
            2'b10:   new_half = old_half | arg;
            2'b11:   new_half = old_half & ~arg;
            default: new_half = arg;
        endcase
    end

    // The untouched half of a 64-bit counter is carried over as-is, so a
    // half write also freezes the other half for that one cycle.
    assign new_half64 = 64'(new_half);
    assign new_full   = (old_full & ~acc_mask)
                      | (sel_hi ? (new_half64 << 32) : (new_half64 & acc_mask));

    // req_ready is gated by reset so it reads 0 while reset is held.
    assign req_ready_w = (state_q == IDLE) && reset;
    assign accept      = bus.req_valid && req_ready_w;

    // ---- next state ----
    always_comb begin
        state_d    = state_q;
        resp_d     = resp_q;
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = retire ? (minstret_q + 64'd1) : minstret_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RESP;
                    resp_d  = '0;
                    if (trap) begin
                        resp_d.trap = 1'b1;
                    end else begin
                        resp_d.rd_addr  = rd;
                        resp_d.rd_wdata = rd_nz ? old_half : '0;
                        if (sel_misa) begin
                            // WARL constant: write accepted but value and wmask unchanged.
                            resp_d.misa_rmask = rd_nz ? {XLEN{1'b1}} : '0;
                            resp_d.misa_rdata = misa_x;
                            resp_d.misa_wdata = misa_x;
                        end
                        if (sel_cyc) begin
                            resp_d.cyc_rmask = rd_nz ? acc_mask : '0;
                            resp_d.cyc_wmask = wr ? acc_mask : '0;
                            resp_d.cyc_rdata = mcycle_q;
                            resp_d.cyc_wdata = new_full;
                            if (wr) mcycle_d = new_full;
                        end
                        if (sel_ins) begin
                            resp_d.ins_rmask = rd_nz ? acc_mask : '0;
                            resp_d.ins_wmask = wr ? acc_mask : '0;
                            resp_d.ins_rdata = minstret_q;
                            resp_d.ins_wdata = new_full;
                            if (wr) minstret_d = new_full;
                        end
                    end
                end
            end
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            resp_q     <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            state_q    <= state_d;
            resp_q     <= resp_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    // ---- outputs ----
    assign bus.req_ready          = req_ready_w;
    assign bus.resp_valid         = (state_q == RESP);
    assign bus.resp_trap          = resp_q.trap;
    assign bus.resp_rd_addr       = resp_q.rd_addr;
    assign bus.resp_rd_wdata      = resp_q.rd_wdata;
    assign bus.csr_misa_rmask     = resp_q.misa_rmask;
    assign bus.csr_misa_wmask     = resp_q.misa_wmask;
    assign bus.csr_misa_rdata     = resp_q.misa_rdata;
    assign bus.csr_misa_wdata     = resp_q.misa_wdata;
    assign bus.csr_mcycle_rmask   = resp_q.cyc_rmask;
    assign bus.csr_mcycle_wmask   = resp_q.cyc_wmask;
    assign bus.csr_mcycle_rdata   = resp_q.cyc_rdata;
    assign bus.csr_mcycle_wdata   = resp_q.cyc_wdata;
    assign bus.csr_minstret_rmask = resp_q.ins_rmask;
    assign bus.csr_minstret_wmask = resp_q.ins_wmask;
    assign bus.csr_minstret_rdata = resp_q.ins_rdata;
    assign bus.csr_minstret_wdata = resp_q.ins_wdata;

endmodule

// File: tb/tb_csr_counter_unit.sv
// tb_csr_counter_unit
//   Directed bench for csr_counter_unit (XLEN=32). Each transaction is
//   driven just after a rising edge, accepted at the next edge and its
//   response sampled 1 time unit after that edge.
module tb_csr_counter_unit;

    logic clock;
    logic reset;
    logic retire;

    csr_counter_unit_if #(.XLEN(32)) bus ();

    csr_counter_unit #(.XLEN(32)) dut (
        .clock  (clock),
        .reset  (reset),
        .retire (retire),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cycles elapsed since reset release: the expected free-running mcycle.
    logic [63:0] edges;
    always @(posedge clock or negedge reset) begin
        if (!reset) edges <= 64'd0;
        else        edges <= edges + 64'd1;
    end

    int          n_pass  = 0;
    int          n_total = 0;
    logic [63:0] t_cyc;

    localparam logic [1:0] MODE_U = 2'd0;
    localparam logic [1:0] MODE_M = 2'd3;

    function automatic logic [31:0] csr_insn(input logic [11:0] csr, input logic [4:0] rs1,
                                             input logic [2:0] f3, input logic [4:0] rd);
        return {csr, rs1, f3, rd, 7'b1110011};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Offer one request; returns 1 unit after the accepting edge.
    task automatic issue(input logic [31:0] insn, input logic [31:0] rs1,
                         input logic [1:0] mode, input logic ret);
        bus.req_valid     = 1'b1;
        bus.req_insn      = insn;
        bus.req_rs1_rdata = rs1;
        bus.req_mode      = mode;
        retire            = ret;
        t_cyc             = edges;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        retire        = 1'b0;
    endtask

    // Let the response drain (resp_ready=1) back to IDLE.
    task automatic drain();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset             = 1'b0;
        retire            = 1'b0;
        bus.req_valid     = 1'b0;
        bus.req_insn      = 32'h0;
        bus.req_rs1_rdata = 32'h0;
        bus.req_mode      = MODE_M;
        bus.resp_ready    = 1'b1;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_trap", bus.resp_trap, 0);
        chk("rst_rd_wdata", bus.resp_rd_wdata, 0);
        chk("rst_cyc_rdata", bus.csr_mcycle_rdata, 0);
        reset = 1'b1;
        #1;
        chk("rel_req_ready", bus.req_ready, 1);

        // csrrs x5, mcycle, x0 accepted when mcycle=10
        repeat (10) @(posedge clock);
        #1;
        issue(csr_insn(12'hB00, 5'd0, 3'b010, 5'd5), 32'h0, MODE_M, 1'b0);
        chk("rd10_valid", bus.resp_valid, 1);
        chk("rd10_ready", bus.req_ready, 0);
        chk("rd10_trap", bus.resp_trap, 0);
        chk("rd10_rd_addr", bus.resp_rd_addr, 5);
        chk("rd10_wdata", bus.resp_rd_wdata, 32'd10);
        chk("rd10_rmask", bus.csr_mcycle_rmask, 64'hFFFF_FFFF);
        chk("rd10_wmask", bus.csr_mcycle_wmask, 0);
        chk("rd10_rdata", bus.csr_mcycle_rdata, 64'd10);
        drain();

        // csrrw x0, minstret, x7 with retire in the same cycle
        issue(csr_insn(12'hB02, 5'd7, 3'b001, 5'd0), 32'h55, MODE_M, 1'b1);
        chk("wi_trap", bus.resp_trap, 0);
        chk("wi_rd_addr", bus.resp_rd_addr, 0);
        chk("wi_rd_wdata", bus.resp_rd_wdata, 0);
        chk("wi_rmask", bus.csr_minstret_rmask, 0);
        chk("wi_wmask", bus.csr_minstret_wmask, 64'hFFFF_FFFF);
        chk("wi_rdata", bus.csr_minstret_rdata, 0);
        chk("wi_wdata", bus.csr_minstret_wdata, 64'h55);
        chk("wi_cyc_wmask", bus.csr_mcycle_wmask, 0);
        drain();
        issue(csr_insn(12'hB02, 5'd0, 3'b010, 5'd8), 32'h0, MODE_M, 1'b0);
        chk("ri_wdata", bus.resp_rd_wdata, 32'h55);
        drain();

        // three retirements
        retire = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        retire = 1'b0;
        issue(csr_insn(12'hB02, 5'd0, 3'b010, 5'd8), 32'h0, MODE_M, 1'b0);
        chk("ret3_wdata", bus.resp_rd_wdata, 32'h58);
        drain();

        // csrrci x10, minstret, 8 : 0x58 & ~0x08 = 0x50
        issue(csr_insn(12'hB02, 5'd8, 3'b111, 5'd10), 32'hFFFF_FFFF, MODE_M, 1'b0);
        chk("ci_rd_wdata", bus.resp_rd_wdata, 32'h58);
        chk("ci_wdata", bus.csr_minstret_wdata, 64'h50);
        chk("ci_wmask", bus.csr_minstret_wmask, 64'hFFFF_FFFF);
        drain();

        // U-mode csrrw x1, mcycle, x2 -> trap
        issue(csr_insn(12'hB00, 5'd2, 3'b001, 5'd1), 32'h1234, MODE_U, 1'b0);
        chk("u_w_trap", bus.resp_trap, 1);
        chk("u_w_rd_addr", bus.resp_rd_addr, 0);
        chk("u_w_rd_wdata", bus.resp_rd_wdata, 0);
        chk("u_w_rmask", bus.csr_mcycle_rmask, 0);
        chk("u_w_wmask", bus.csr_mcycle_wmask, 0);
        drain();

        // U-mode csrrsi x3, cycle, 1 -> trap (read-only alias)
        issue(csr_insn(12'hC00, 5'd1, 3'b110, 5'd3), 32'h0, MODE_U, 1'b0);
        chk("u_si_trap", bus.resp_trap, 1);
        chk("u_si_rmask", bus.csr_mcycle_rmask, 0);
        drain();

        // U-mode csrrs x3, cycle, x0 -> count, mcycle unaffected by traps
        issue(csr_insn(12'hC00, 5'd0, 3'b010, 5'd3), 32'h0, MODE_U, 1'b0);
        chk("u_r_trap", bus.resp_trap, 0);
        chk("u_r_rd_addr", bus.resp_rd_addr, 3);
        chk("u_r_wdata", bus.resp_rd_wdata, t_cyc);
        chk("u_r_rdata", bus.csr_mcycle_rdata, t_cyc);
        drain();

        // unmapped address (0x340) traps
        issue(csr_insn(12'h340, 5'd0, 3'b010, 5'd3), 32'h0, MODE_M, 1'b0);
        chk("unmap_trap", bus.resp_trap, 1);
        drain();

        // misa write: no trap, constant value, wmask 0
        issue(csr_insn(12'h301, 5'd1, 3'b001, 5'd9), 32'hFFFF, MODE_M, 1'b0);
        chk("misa_trap", bus.resp_trap, 0);
        chk("misa_rd_wdata", bus.resp_rd_wdata, 32'h4000_0100);
        chk("misa_rmask", bus.csr_misa_rmask, 32'hFFFF_FFFF);
        chk("misa_wmask", bus.csr_misa_wmask, 0);
        chk("misa_wdata", bus.csr_misa_wdata, 32'h4000_0100);
        drain();
        issue(csr_insn(12'h301, 5'd0, 3'b010, 5'd9), 32'h0, MODE_U, 1'b0);
        chk("misa_u_trap", bus.resp_trap, 1);
        drain();

        // csrrw x4, mcycleh, x6 with rs1=1
        issue(csr_insn(12'hB80, 5'd6, 3'b001, 5'd4), 32'h1, MODE_M, 1'b0);
`ifdef CSR_COUNTER_HIGH_EN
        chk("hi_trap", bus.resp_trap, 0);
        chk("hi_rd_wdata", bus.resp_rd_wdata, 0);
        chk("hi_wmask", bus.csr_mcycle_wmask, 64'hFFFF_FFFF_0000_0000);
        chk("hi_rmask", bus.csr_mcycle_rmask, 64'hFFFF_FFFF_0000_0000);
        chk("hi_wdata", bus.csr_mcycle_wdata, {32'h1, t_cyc[31:0]});
        drain();
        issue(csr_insn(12'hB80, 5'd0, 3'b010, 5'd4), 32'h0, MODE_M, 1'b0);
        chk("hi_read", bus.resp_rd_wdata, 32'h1);
        drain();
        // low half missed the write cycle's increment, then kept counting
        issue(csr_insn(12'hB00, 5'd0, 3'b010, 5'd4), 32'h0, MODE_M, 1'b0);
        chk("hi_lo_read", bus.resp_rd_wdata, t_cyc[31:0] - 32'd1);
        chk("hi_full", bus.csr_mcycle_rdata, {32'h1, t_cyc[31:0] - 32'd1});
`else
        chk("hi_trap", bus.resp_trap, 1);
        chk("hi_wmask", bus.csr_mcycle_wmask, 0);
        chk("hi_rd_addr", bus.resp_rd_addr, 0);
`endif
        drain();

        // response held with resp_ready=0, then reset mid-hold
        bus.resp_ready = 1'b0;
        issue(csr_insn(12'hB02, 5'd0, 3'b010, 5'd5), 32'h0, MODE_M, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            chk("hold_valid", bus.resp_valid, 1);
            chk("hold_wdata", bus.resp_rd_wdata, 32'h50);
        end
        #2;
        reset = 1'b0;
        #1;
        chk("mrst_valid", bus.resp_valid, 0);
        chk("mrst_ready", bus.req_ready, 0);
        chk("mrst_rd_wdata", bus.resp_rd_wdata, 0);
        chk("mrst_rmask", bus.csr_minstret_rmask, 0);
        @(posedge clock);
        #1;
        reset          = 1'b1;
        bus.resp_ready = 1'b1;
        #1;
        chk("mrel_ready", bus.req_ready, 1);
        issue(csr_insn(12'hB00, 5'd0, 3'b010, 5'd5), 32'h0, MODE_M, 1'b0);
        chk("mrel_cyc", bus.resp_rd_wdata, 0);
        drain();
        issue(csr_insn(12'hB02, 5'd0, 3'b010, 5'd5), 32'h0, MODE_M, 1'b0);
        chk("mrel_ins", bus.resp_rd_wdata, 0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
